// File: rtl/alu2_pkg.sv
// Shared types for the digit-serial ALU: one-hot op encoding and sequencer states.
package alu2_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_ROL = 2;
  localparam int OP_AND = 3;
  localparam int OP_ORR = 4;
  localparam int OP_EOR = 5;
  localparam int OP_W   = 6;

  typedef logic [OP_W-1:0] op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam op_t OP_ADD_1H = op_t'(1 << OP_ADD);

  function automatic logic is_onehot(input op_t op);
    return (op != '0) && ((op & (op - op_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu2.sv
// Combinational 2-bit ALU slice; one-hot op, carry in/out for the arithmetic ops.
module alu2
  import alu2_pkg::*;
(
  input  op_t        op_i,
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       c_i,
  output logic [1:0] r_o,
  output logic       c_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    r_o = 2'b00;
    c_o = 1'b0;
    if (op_i[OP_ADD]) begin
      {c_o, r_o} = {1'b0, a_i} + {1'b0, b_i} + {2'b00, c_i};
    end else if (op_i[OP_SUB]) begin
      {c_o, r_o} = {1'b0, a_i} + {1'b0, ~b_i} + {2'b00, c_i};
    end else if (op_i[OP_ROL]) begin
      r_o = {a_i[0], c_i};
      c_o = a_i[1];
    end else if (op_i[OP_AND]) begin
      r_o = a_i & b_i;
    end else if (op_i[OP_ORR]) begin
      r_o = a_i | b_i;
    end else if (op_i[OP_EOR]) begin
      r_o = a_i ^ b_i;
    end
  end

endmodule

// File: rtl/alu2_sequencer.sv
// Runs a WIDTH-bit ALU op over one shared 2-bit slice, LSB digit first, with a
// valid/ready request port and a valid/ready result port.
module alu2_sequencer
  import alu2_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             rx_clk,
  input  logic             rx_reset,
  input  logic             rx_valid,
  output logic             tx_ready,
  input  logic [5:0]       rx_what_op,
  input  logic             rx_carryflag,
  input  logic [WIDTH-1:0] rx_operand0,
  input  logic [WIDTH-1:0] rx_operand1,
  output logic             tx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] tx_result,
  output logic             tx_carryflag,
  output logic             tx_zeroflag,
  output logic             tx_signflag,
  output logic             tx_opfault
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("alu2_sequencer: WIDTH must be even and >= 4");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             c_q, c_d, zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, zflag_q, zflag_d;
  logic             sflag_q, sflag_d, opfault_q, opfault_d;

  logic       accept, last_digit, logical_op;
  op_t        slice_op;
  logic [1:0] slice_b, slice_r, dig_r;
  logic       slice_c, dig_c;

  assign accept     = (state_q == IDLE) && rx_valid;
  assign last_digit = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign logical_op = op_q[OP_AND] | op_q[OP_ORR] | op_q[OP_EOR];

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its pre-edge value regardless of statement order.
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tx_ready = 1'b0;
    tx_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        if (rx_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        tx_valid = 1'b1;
        if (rx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Arithmetic and ROL run the slice as ADD (ROL's digit is built locally below);
  // outside RUN or on a bad opcode the slice still sees a legal one-hot ADD.
  always_comb begin
    slice_op = OP_ADD_1H;
    slice_b  = b_q[1:0];
    if (state_q == RUN && !fault_q) begin
      if (logical_op && !(op_q[OP_ADD] | op_q[OP_SUB] | op_q[OP_ROL])) slice_op = op_q;
      if (op_q[OP_SUB]) slice_b = ~b_q[1:0];
    end
  end

  alu2 u_alu2 (
    .op_i (slice_op),
    .a_i  (a_q[1:0]),
    .b_i  (slice_b),
    .c_i  (c_q),
    .r_o  (slice_r),
    .c_o  (slice_c)
  );

  always_comb begin
    dig_r = slice_r;
    dig_c = slice_c;
    if (fault_q) begin
      dig_r = 2'b00;
      dig_c = 1'b0;
    end else if (op_q[OP_ROL]) begin
      dig_r = {a_q[0], c_q};
      dig_c = a_q[1];
    end else if (logical_op) begin
      dig_c = 1'b0;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    fault_d   = fault_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    c_d       = c_q;
    zero_d    = zero_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zflag_d   = zflag_q;
    sflag_d   = sflag_q;
    opfault_d = opfault_q;
    if (accept) begin
      cnt_d   = '0;
      op_d    = rx_what_op;
      fault_d = !is_onehot(rx_what_op);
      a_d     = rx_operand0;
      b_d     = rx_operand1;
      res_d   = '0;
      c_d     = rx_carryflag;
      zero_d  = 1'b1;
    end else if (state_q == RUN) begin
      a_d    = a_q >> 2;
      b_d    = b_q >> 2;
      res_d  = {dig_r, res_q[WIDTH-1:2]};
      c_d    = dig_c;
      zero_d = zero_q & (dig_r == 2'b00);
      if (!last_digit) cnt_d = cnt_q + CNT_W'(1);
      if (last_digit) begin
        result_d  = {dig_r, res_q[WIDTH-1:2]};
        carry_d   = dig_c;
        zflag_d   = zero_q & (dig_r == 2'b00);
        sflag_d   = dig_r[1];
        opfault_d = fault_q;
      end
    end
  end

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) begin
      cnt_q     <= '0;
      op_q      <= OP_ADD_1H;
      fault_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      zero_q    <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zflag_q   <= 1'b0;
      sflag_q   <= 1'b0;
      opfault_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      fault_q   <= fault_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      c_q       <= c_d;
      zero_q    <= zero_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zflag_q   <= zflag_d;
      sflag_q   <= sflag_d;
      opfault_q <= opfault_d;
    end
  end

  assign tx_result    = result_q;
  assign tx_carryflag = carry_q;
  assign tx_zeroflag  = zflag_q;
  assign tx_signflag  = sflag_q;
  assign tx_opfault   = opfault_q;

endmodule

// File: tb/tb_alu2_sequencer.sv
// Directed bench for alu2_sequencer at WIDTH = 16 with hand-computed results.
module tb_alu2_sequencer;

  localparam int WIDTH = 16;
  localparam logic [5:0] ADD = 6'b000001, SUB = 6'b000010, ROL = 6'b000100;
  localparam logic [5:0] AND = 6'b001000, ORR = 6'b010000, EOR = 6'b100000;

  logic             rx_clk = 1'b0;
  logic             rx_reset, rx_valid, rx_ready, rx_carryflag;
  logic [5:0]       rx_what_op;
  logic [WIDTH-1:0] rx_operand0, rx_operand1;
  logic             tx_ready, tx_valid, tx_carryflag, tx_zeroflag, tx_signflag, tx_opfault;
  logic [WIDTH-1:0] tx_result;

  int passed = 0;
  int total  = 0;

  alu2_sequencer #(.WIDTH(WIDTH)) dut (
    .rx_clk       (rx_clk),
    .rx_reset     (rx_reset),
    .rx_valid     (rx_valid),
    .tx_ready     (tx_ready),
    .rx_what_op   (rx_what_op),
    .rx_carryflag (rx_carryflag),
    .rx_operand0  (rx_operand0),
    .rx_operand1  (rx_operand1),
    .tx_valid     (tx_valid),
    .rx_ready     (rx_ready),
    .tx_result    (tx_result),
    .tx_carryflag (tx_carryflag),
    .tx_zeroflag  (tx_zeroflag),
    .tx_signflag  (tx_signflag),
    .tx_opfault   (tx_opfault)
  );

  always #5 rx_clk = ~rx_clk;

  // {result, C, Z, S, opfault}
  function automatic logic [19:0] obs();
    return {tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_opfault};
  endfunction

  // Issues one request and returns once tx_valid is seen; lat numbers the
  // accept cycle as 0, or is 99 if the handshake never happened.
  task automatic do_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output int lat);
    int w = 0;
    while (!tx_ready && w < 30) begin
      @(posedge rx_clk); #1; w++;
    end
    rx_what_op = op; rx_operand0 = a; rx_operand1 = b; rx_carryflag = cin;
    rx_valid = 1'b1;
    @(posedge rx_clk); #1;
    rx_valid = 1'b0;
    lat = 1;
    while (!tx_valid && lat < 30) begin
      @(posedge rx_clk); #1; lat++;
    end
    if (!tx_valid) lat = 99;
  endtask

  task automatic test_reset();
    total++;
    if ({tx_ready, tx_valid, obs()} !== {2'b10, 20'h0}) begin
      $display("FAIL reset_state: got rdy/vld/obs %b/%b/%h want 1/0/00000", tx_ready, tx_valid, obs());
    end else passed++;
  endtask

  task automatic test_add();
    int lat;
    do_op(ADD, 16'hFFFF, 16'h0001, 1'b0, lat);
    total++;
    if (lat !== 9) $display("FAIL add_latency: got %0d want 9", lat);
    else passed++;
    total++;
    if (obs() !== {16'h0000, 4'b1100}) $display("FAIL add_ffff_1: got %h want %h", obs(), {16'h0000, 4'b1100});
    else passed++;
    do_op(ADD, 16'h1234, 16'h0F0F, 1'b1, lat);
    total++;
    if (obs() !== {16'h2144, 4'b0000}) $display("FAIL add_cin: got %h want %h", obs(), {16'h2144, 4'b0000});
    else passed++;
  endtask

  task automatic test_sub();
    int lat;
    do_op(SUB, 16'h0005, 16'h0007, 1'b1, lat);
    total++;
    if (obs() !== {16'hFFFE, 4'b0010}) $display("FAIL sub_5_7: got %h want %h", obs(), {16'hFFFE, 4'b0010});
    else passed++;
    do_op(SUB, 16'h0007, 16'h0005, 1'b1, lat);
    total++;
    if (obs() !== {16'h0002, 4'b1000}) $display("FAIL sub_7_5: got %h want %h", obs(), {16'h0002, 4'b1000});
    else passed++;
  endtask

  task automatic test_rol();
    int lat;
    do_op(ROL, 16'h8001, 16'hFFFF, 1'b1, lat);
    total++;
    if (obs() !== {16'h0003, 4'b1000}) $display("FAIL rol_8001: got %h want %h", obs(), {16'h0003, 4'b1000});
    else passed++;
    do_op(ROL, 16'h4000, 16'h1234, 1'b0, lat);
    total++;
    if (obs() !== {16'h8000, 4'b0010}) $display("FAIL rol_4000: got %h want %h", obs(), {16'h8000, 4'b0010});
    else passed++;
  endtask

  task automatic test_logic();
    int lat;
    do_op(AND, 16'hF0F0, 16'h3C3C, 1'b1, lat);
    total++;
    if (obs() !== {16'h3030, 4'b0000}) $display("FAIL and: got %h want %h", obs(), {16'h3030, 4'b0000});
    else passed++;
    do_op(ORR, 16'hF0F0, 16'h3C3C, 1'b1, lat);
    total++;
    if (obs() !== {16'hFCFC, 4'b0010}) $display("FAIL orr: got %h want %h", obs(), {16'hFCFC, 4'b0010});
    else passed++;
    do_op(EOR, 16'hF0F0, 16'h3C3C, 1'b1, lat);
    total++;
    if (obs() !== {16'hCCCC, 4'b0010}) $display("FAIL eor: got %h want %h", obs(), {16'hCCCC, 4'b0010});
    else passed++;
    do_op(EOR, 16'h1234, 16'h1234, 1'b1, lat);
    total++;
    if (obs() !== {16'h0000, 4'b0100}) $display("FAIL eor_zero: got %h want %h", obs(), {16'h0000, 4'b0100});
    else passed++;
    do_op(AND, 16'h0100, 16'h0100, 1'b0, lat);
    total++;
    if (obs() !== {16'h0100, 4'b0000}) $display("FAIL and_mid_digit: got %h want %h", obs(), {16'h0100, 4'b0000});
    else passed++;
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1, lat = 0;
    rx_what_op = ADD; rx_operand0 = 16'h0001; rx_operand1 = 16'h0002; rx_carryflag = 1'b0;
    rx_valid = 1'b1;
    for (int e = 0; e < 30 && second < 0; e++) begin
      if (tx_ready) begin
        if (first < 0) first = e;
        else second = e;
      end
      @(posedge rx_clk); #1;
    end
    rx_valid = 1'b0;
    total++;
    if (second - first !== 10) $display("FAIL b2b_period: got %0d want 10", second - first);
    else passed++;
    while (!tx_valid && lat < 30) begin
      @(posedge rx_clk); #1; lat++;
    end
    total++;
    if ({tx_valid, obs()} !== {1'b1, 16'h0003, 4'b0000}) begin
      $display("FAIL b2b_result: got vld/obs %b/%h want 1/%h", tx_valid, obs(), {16'h0003, 4'b0000});
    end else passed++;
    repeat (4) begin
      @(posedge rx_clk); #1;
    end
    total++;
    if ({tx_valid, tx_ready, obs()} !== {2'b01, 16'h0003, 4'b0000}) begin
      $display("FAIL hold_after_handshake: got vld/rdy/obs %b/%b/%h", tx_valid, tx_ready, obs());
    end else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    rx_ready = 1'b0;
    do_op(ADD, 16'h1111, 16'h2222, 1'b0, lat);
    rx_what_op = AND; rx_operand0 = 16'h0000; rx_operand1 = 16'h0000; rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge rx_clk); #1;
      total++;
      if ({tx_valid, tx_ready, obs()} !== {2'b10, 16'h3333, 4'b0000}) begin
        $display("FAIL backpressure_hold[%0d]: got vld/rdy/obs %b/%b/%h want 1/0/%h",
                 i, tx_valid, tx_ready, obs(), {16'h3333, 4'b0000});
      end else passed++;
    end
    rx_valid = 1'b0;
    rx_ready = 1'b1;
    @(posedge rx_clk); #1;
    total++;
    if ({tx_valid, tx_ready} !== 2'b01) $display("FAIL backpressure_release: got vld/rdy %b/%b want 0/1", tx_valid, tx_ready);
    else passed++;
    repeat (12) begin
      @(posedge rx_clk); #1;
    end
    total++;
    if ({tx_valid, tx_ready, obs()} !== {2'b01, 16'h3333, 4'b0000}) begin
      $display("FAIL backpressure_no_accept: got vld/rdy/obs %b/%b/%h", tx_valid, tx_ready, obs());
    end else passed++;
  endtask

  task automatic test_reset_abort();
    int w = 0;
    logic seen_valid = 1'b0;
    while (!tx_ready && w < 30) begin
      @(posedge rx_clk); #1; w++;
    end
    rx_what_op = ADD; rx_operand0 = 16'h1234; rx_operand1 = 16'h4321; rx_carryflag = 1'b0;
    rx_valid = 1'b1;
    @(posedge rx_clk); #1;
    rx_valid = 1'b0;
    repeat (3) begin
      @(posedge rx_clk); #1;
    end
    rx_reset = 1'b1;
    #2;
    total++;
    if ({tx_ready, tx_valid, obs()} !== {2'b10, 20'h0}) begin
      $display("FAIL reset_abort_async: got rdy/vld/obs %b/%b/%h want 1/0/00000", tx_ready, tx_valid, obs());
    end else passed++;
    #2;
    rx_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge rx_clk); #1;
      if (tx_valid) seen_valid = 1'b1;
    end
    total++;
    if ({seen_valid, tx_ready, obs()} !== {2'b01, 20'h0}) begin
      $display("FAIL reset_abort_after: got seen_vld/rdy/obs %b/%b/%h want 0/1/00000", seen_valid, tx_ready, obs());
    end else passed++;
  endtask

  task automatic test_opfault();
    int lat;
    do_op(6'b000011, 16'h0005, 16'h0007, 1'b1, lat);
    total++;
    if (lat !== 9) $display("FAIL opfault_latency: got %0d want 9", lat);
    else passed++;
    total++;
    if (obs() !== {16'h0000, 4'b0101}) $display("FAIL opfault_000011: got %h want %h", obs(), {16'h0000, 4'b0101});
    else passed++;
    do_op(ADD, 16'h0001, 16'h0001, 1'b0, lat);
    do_op(6'b000000, 16'hFFFF, 16'hFFFF, 1'b1, lat);
    total++;
    if (obs() !== {16'h0000, 4'b0101}) $display("FAIL opfault_zero_op: got %h want %h", obs(), {16'h0000, 4'b0101});
    else passed++;
  endtask

  initial begin
    rx_reset = 1'b1; rx_valid = 1'b0; rx_ready = 1'b1; rx_carryflag = 1'b0;
    rx_what_op = ADD; rx_operand0 = '0; rx_operand1 = '0;
    repeat (2) @(posedge rx_clk);
    #1;
    rx_reset = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_rol();
    test_logic();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_opfault();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
